seg7_code_tx: RTL and testbench

// - Transmit side of the 6-bit parity-protected display code link: accepts 5-bit symbols, appends a

---
 rtl/seg7_code_pkg.sv | 23 ++
 rtl/seg7_code_tx_if.sv | 24 ++
 rtl/seg7_parity_gen.sv | 14 +
 rtl/seg7_code_tx.sv | 128 ++++++++++++
 tb/tb_seg7_code_tx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_code_pkg.sv
// Shared definitions for the 6-bit parity-protected display code link.
// Used by both the transmitter and the checker side.
package seg7_code_pkg;

  localparam int SYM_W      = 5;
  localparam int CODE_W     = 6;
  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Code word is {data, parity}; odd selects odd parity and flip corrupts the parity bit.
  function automatic logic [CODE_W-1:0] make_code(input logic [SYM_W-1:0] data,
                                                  input logic             odd,
                                                  input logic             flip);
    return {data, (^data) ^ odd ^ flip};
  endfunction

endpackage

// File: rtl/seg7_code_tx_if.sv
// Symbol handshake between a symbol source and the code-word transmitter.
interface seg7_code_tx_if;
  import seg7_code_pkg::*;

  logic [SYM_W-1:0] sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic             force_par_err;

  modport master (
    output sym_in,
    output sym_valid,
    output force_par_err,
    input  sym_ready
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    input  force_par_err,
    output sym_ready
  );

endinterface

// File: rtl/seg7_parity_gen.sv
// Combinational symbol-to-code-word generator; also usable as a reference model.
module seg7_parity_gen
  import seg7_code_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic [SYM_W-1:0]  data,
  input  logic              flip,
  output logic [CODE_W-1:0] code
);

  assign code = make_code(data, ODD_PARITY, flip);

endmodule

// File: rtl/seg7_code_tx.sv
// Serial transmitter for parity-protected display symbols: start bit, 6 code bits MSB first, stop bit.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | line high, ready for a symbol; illegal symbols pulse range_err
//   START | line low for one bit time
//   DATA  | shifting the 6-bit code word out, code[5] first
//   STOP  | line high for one bit time, then back to IDLE
module seg7_code_tx
  import seg7_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_SYMBOL   = 25,
  parameter bit ODD_PARITY   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_code_tx_if.slave     sym_bus,
  output logic [CODE_W-1:0] code_out,
  output logic              tx,
  output logic              busy,
  output logic              range_err
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(CODE_W - 1);
  localparam logic [SYM_W-1:0]  MAX_SYM   = SYM_W'(MAX_SYMBOL);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_START = 2'(START);
  localparam logic [1:0] ST_DATA  = 2'(DATA);
  localparam logic [1:0] ST_STOP  = 2'(STOP);

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] code_nxt;
  logic              accept;
  logic              sym_legal;
  logic              baud_wrap;

  seg7_parity_gen #(
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_gen (
    .data (sym_bus.sym_in),
    .flip (sym_bus.force_par_err),
    .code (code_nxt)
  );

  assign sym_bus.sym_ready = (state == ST_IDLE);
  assign busy              = (state != ST_IDLE);
  assign accept            = sym_bus.sym_valid & sym_bus.sym_ready;
  assign sym_legal         = (sym_bus.sym_in <= MAX_SYM);
  assign baud_wrap         = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      code_out  <= '0;
      tx        <= 1'b1;
      range_err <= 1'b0;
    end else begin
      range_err <= accept & ~sym_legal;

      case (state)
        ST_IDLE: begin
          if (accept && sym_legal) begin
            code_out <= code_nxt;
            shreg    <= code_nxt;
            state    <= ST_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        ST_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            tx       <= shreg[CODE_W-1];
            shreg    <= {shreg[CODE_W-2:0], 1'b0};
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[CODE_W-1];
              shreg   <= {shreg[CODE_W-2:0], 1'b0};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_code_tx.sv
// Self-checking bench for seg7_code_tx: directed link scenarios plus random symbols
// against a frame-level reference built from the parity rule.
module tb_seg7_code_tx;

  localparam int CPB      = 4;
  localparam int MAX_SYM  = 25;
  localparam bit ODD      = 1'b1;
  localparam int FRAME_CY = 8 * CPB;

  logic       clk;
  logic       rst_n;
  logic [5:0] code_out;
  logic       tx;
  logic       busy;
  logic       range_err;

  int         n_checks;
  int         n_errors;
  logic [5:0] last_code;

  seg7_code_tx_if bus ();

  seg7_code_tx #(
    .CLKS_PER_BIT (CPB),
    .MAX_SYMBOL   (MAX_SYM),
    .ODD_PARITY   (ODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_bus   (bus.slave),
    .code_out  (code_out),
    .tx        (tx),
    .busy      (busy),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference code word: pick the parity bit that makes the total ones count odd (or even), then flip.
  function automatic logic [5:0] ref_code(input int sym, input bit flip);
    int ones;
    int p;
    ones = $countones(sym[4:0]);
    if (ODD) p = (ones % 2 == 0) ? 1 : 0;
    else     p = (ones % 2 == 0) ? 0 : 1;
    if (flip) p = 1 - p;
    return 6'((sym * 2) + p);
  endfunction

  // Entered at a falling edge where the block is expected ready; leaves at the next such edge.
  task automatic send_frame(input int sym, input bit flip, input bit hold);
    logic [5:0] code;
    logic [7:0] frame;
    code  = ref_code(sym, flip);
    frame = {1'b0, code, 1'b1};
    check("ready_before_send", bus.sym_ready, 1);
    bus.sym_in        = 5'(sym);
    bus.sym_valid     = 1'b1;
    bus.force_par_err = flip;
    for (int k = 0; k < FRAME_CY; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("code_out", code_out, code);
        last_code = code;
        if (!hold) begin
          bus.sym_valid     = 1'b0;
          bus.force_par_err = 1'b0;
        end
      end
      check($sformatf("tx_k%0d", k), tx, frame[7 - k / CPB]);
      check("busy_in_frame", busy, 1);
      check("ready_in_frame", bus.sym_ready, 0);
      check("range_err_in_frame", range_err, 0);
    end
    @(negedge clk);
    check("ready_after_frame", bus.sym_ready, 1);
    check("busy_after_frame", busy, 0);
    check("tx_after_frame", tx, 1);
  endtask

  task automatic offer_bad(input int sym);
    bus.sym_in    = 5'(sym);
    bus.sym_valid = 1'b1;
    @(negedge clk);
    check("range_err_pulse", range_err, 1);
    check("ready_on_reject", bus.sym_ready, 1);
    check("tx_on_reject", tx, 1);
    check("code_out_on_reject", code_out, last_code);
    bus.sym_valid = 1'b0;
    @(negedge clk);
    check("range_err_clear", range_err, 0);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_ready", bus.sym_ready, 1);
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_code_out", code_out, last_code);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    last_code         = 6'd0;
    rst_n             = 1'b0;
    bus.sym_in        = 5'd0;
    bus.sym_valid     = 1'b0;
    bus.force_par_err = 1'b0;

    // Reset values, held and after release.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", bus.sym_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_code_out", code_out, 0);
    check("rst_range_err", range_err, 0);
    rst_n = 1'b1;
    idle_check(2);

    send_frame(0, 1'b0, 1'b0);
    check("sym0_code", last_code, 6'b000001);

    send_frame(1, 1'b0, 1'b1);
    send_frame(2, 1'b0, 1'b1);
    send_frame(25, 1'b0, 1'b0);
    check("sym25_code", code_out, 6'b110010);
    idle_check(3);

    send_frame(0, 1'b1, 1'b0);
    check("forced_par_code", code_out, 6'b000000);

    offer_bad(26);
    offer_bad(31);

    // Sustained illegal symbol pulses range_err every cycle.
    bus.sym_in    = 5'd30;
    bus.sym_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sustained_range_err", range_err, 1);
      check("sustained_code_out", code_out, last_code);
    end
    bus.sym_valid = 1'b0;
    @(negedge clk);
    check("sustained_clear", range_err, 0);

    // Asynchronous reset during the third data bit.
    bus.sym_in    = 5'd21;
    bus.sym_valid = 1'b1;
    @(negedge clk);
    bus.sym_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    repeat (13) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_ready", bus.sym_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_code", code_out, 0);
    last_code = 6'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(2, 1'b0, 1'b0);

    // Random symbols, parity corruption and hold patterns.
    for (int n = 0; n < 24; n++) begin
      int sym;
      bit flip;
      bit hold;
      sym  = int'($urandom_range(0, 31));
      flip = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      if (sym > MAX_SYM) offer_bad(sym);
      else               send_frame(sym, flip, hold);
    end
    bus.sym_valid     = 1'b0;
    bus.force_par_err = 1'b0;
    idle_check(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
